// File: rtl/ula_pkg.sv
// ula_pkg: definitions shared by the execution sequencer, its bus interface
// and the iterative MULT/DIV engine.
//   - data/opcode/funct widths
//   - opcode and funct codes understood by the ULA
//   - sequencer state enum; ITERA exists only when ULA_ITERATIVA_EN is defined
//   - immediate helpers: sign extension and immediate-operand opcode set
`timescale 1ns/1ps
package ula_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;

  localparam logic [OP_W-1:0] OP_ARIT  = 6'd0;
  localparam logic [OP_W-1:0] OP_LOG   = 6'd1;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd2;
  localparam logic [OP_W-1:0] OP_LOAD  = 6'd6;
  localparam logic [OP_W-1:0] OP_STORE = 6'd7;
  localparam logic [OP_W-1:0] OP_IN    = 6'd8;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd10;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd11;
  localparam logic [OP_W-1:0] OP_SUBI  = 6'd20;
  localparam logic [OP_W-1:0] OP_PID   = 6'd28;

  localparam logic [OP_W-1:0] FN_MULT  = 6'd2;
  localparam logic [OP_W-1:0] FN_DIV   = 6'd3;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
`ifdef ULA_ITERATIVA_EN
    ITERA    = 2'd2,
`endif
    RESPONDE = 2'd3
  } estado_t;

  function automatic logic [DATA_W-1:0] extende_sinal(input logic [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

  // Opcodes whose second ULA operand is the instruction immediate.
  function automatic logic usa_imediato(input logic [OP_W-1:0] op);
    return op inside {OP_ADDI, OP_LOAD, OP_STORE, OP_IN, OP_SUBI, OP_PID};
  endfunction

endpackage

// File: rtl/ula_sequenciador_if.sv
// ula_sequenciador_if: every non-clock signal of the execution sequencer.
//   instruction handshake : instr_valid, instr_ready, instrucao, dados_1, dados_2
//   ULA drive/capture     : opcode_ula, funct_ula, a_ula, b_ula, resultado_ula, zero_ula
//   result handshake      : res_valid, res_ready, resultado, desvio
//   status                : ocupado
// master = sequencer side, slave = surrounding datapath (register read, ULA, write-back).
`timescale 1ns/1ps
interface ula_sequenciador_if;
  import ula_pkg::*;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instrucao;
  logic [DATA_W-1:0] dados_1;
  logic [DATA_W-1:0] dados_2;
  logic [OP_W-1:0]   opcode_ula;
  logic [OP_W-1:0]   funct_ula;
  logic [DATA_W-1:0] a_ula;
  logic [DATA_W-1:0] b_ula;
  logic [DATA_W-1:0] resultado_ula;
  logic              zero_ula;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] resultado;
  logic              desvio;
  logic              ocupado;

  modport master (
    input  instr_valid, instrucao, dados_1, dados_2, resultado_ula, zero_ula, res_ready,
    output instr_ready, opcode_ula, funct_ula, a_ula, b_ula, res_valid, resultado, desvio, ocupado
  );

  modport slave (
    output instr_valid, instrucao, dados_1, dados_2, resultado_ula, zero_ula, res_ready,
    input  instr_ready, opcode_ula, funct_ula, a_ula, b_ula, res_valid, resultado, desvio, ocupado
  );

endinterface

// File: rtl/ula_muldiv_iterativo.sv
// ula_muldiv_iterativo: 32-step bit-serial engine, built only with ULA_ITERATIVA_EN.
//   clock, reset     : rising-edge clock, synchronous active-low reset
//   start            : load pulse; the first step happens on the following edge
//   op               : 0 = MULT (low 32 bits of a*b), 1 = DIV (unsigned a/b)
//   a, b             : operands, held stable by the caller for the whole run
//   done             : high during the last step; resultado is valid in that cycle
//   resultado        : value after the current step (combinational)
// DIV by zero yields 32'hFFFFFFFF: every restoring trial subtraction succeeds.
`timescale 1ns/1ps
`ifdef ULA_ITERATIVA_EN
module ula_muldiv_iterativo
  import ula_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] resultado
);

  logic [4:0]        contador;
  logic              ativo;
  logic [DATA_W-1:0] acc;    // product accumulator or quotient shift register
  logic [DATA_W-1:0] resto;  // partial remainder (DIV only)

  logic [DATA_W-1:0] produto_prox;
  logic [DATA_W-1:0] quociente_prox;
  logic [DATA_W-1:0] resto_prox;
  logic [DATA_W:0]   resto_desl;
  logic [DATA_W:0]   diferenca;
  logic              cabe;

  // NOTE: every signal of this always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    // MULT step k adds a<<k when bit k of b is set.
    produto_prox   = acc + (b[contador] ? (a << contador) : '0);
    // DIV step k brings dividend bit 31-k into the remainder (MSB first).
    resto_desl     = {resto, a[5'd31 - contador]};
    diferenca      = resto_desl - {1'b0, b};
    cabe           = (resto_desl >= {1'b0, b});
    resto_prox     = cabe ? diferenca[DATA_W-1:0] : resto_desl[DATA_W-1:0];
    quociente_prox = {acc[DATA_W-2:0], cabe};
  end

  assign resultado = op ? quociente_prox : produto_prox;
  assign done      = ativo && (contador == 5'd31);

  always_ff @(posedge clock) begin
    if (!reset) begin
      contador <= '0;
      ativo    <= 1'b0;
      acc      <= '0;
      resto    <= '0;
    end else if (start) begin
      contador <= '0;
      ativo    <= 1'b1;
      acc      <= '0;
      resto    <= '0;
    end else if (ativo) begin
      acc      <= op ? quociente_prox : produto_prox;
      resto    <= resto_prox;
      contador <= contador + 5'd1;
      if (contador == 5'd31) ativo <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/ula_sequenciador.sv
// ula_sequenciador: multi-cycle execution sequencer in front of the combinational ULA.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   bus (master) : instruction handshake in, ULA operation/operands out,
//                  ULA Resultado/Zero in, result handshake out, ocupado status
// Flow: OCIOSO accepts and registers the ULA inputs, EXECUTA lets the ULA settle
// and captures its outputs, RESPONDE holds the result until res_ready.
// Optional macro ULA_ITERATIVA_EN: opcode 0 with funct MULT/DIV bypasses the ULA
// and runs 32 cycles in ITERA on ula_muldiv_iterativo.
`timescale 1ns/1ps
module ula_sequenciador
  import ula_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  ula_sequenciador_if.master bus
);

  estado_t           estado;
  logic [OP_W-1:0]   opcode_r;
  logic [OP_W-1:0]   funct_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] resultado_r;
  logic              desvio_r;
  logic              res_valid_r;

  logic [OP_W-1:0]   opcode_in;
  logic [OP_W-1:0]   funct_in;
  logic [DATA_W-1:0] b_in;
  logic              aceita;

  assign opcode_in = bus.instrucao[31:26];
  assign funct_in  = bus.instrucao[5:0];
  assign b_in      = usa_imediato(opcode_in) ? extende_sinal(bus.instrucao[15:0]) : bus.dados_2;
  assign aceita    = (estado == OCIOSO) && bus.instr_valid;

`ifdef ULA_ITERATIVA_EN
  logic              iterativo_in;
  logic              mdv_done;
  logic [DATA_W-1:0] mdv_resultado;

  assign iterativo_in = (opcode_in == OP_ARIT) && ((funct_in == FN_MULT) || (funct_in == FN_DIV));

  // The engine steps on the registered operands, which are loaded on the same edge as start.
  ula_muldiv_iterativo u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .start     (aceita && iterativo_in),
    .op        (funct_r == FN_DIV),
    .a         (a_r),
    .b         (b_r),
    .done      (mdv_done),
    .resultado (mdv_resultado)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= OCIOSO;
      opcode_r    <= '0;
      funct_r     <= '0;
      a_r         <= '0;
      b_r         <= '0;
      resultado_r <= '0;
      desvio_r    <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (aceita) begin
            opcode_r <= opcode_in;
            funct_r  <= funct_in;
            a_r      <= bus.dados_1;
            b_r      <= b_in;
`ifdef ULA_ITERATIVA_EN
            estado   <= iterativo_in ? ITERA : EXECUTA;
`else
            estado   <= EXECUTA;
`endif
          end
        end
        EXECUTA: begin
          resultado_r <= bus.resultado_ula;
          desvio_r    <= bus.zero_ula;
          res_valid_r <= 1'b1;
          estado      <= RESPONDE;
        end
`ifdef ULA_ITERATIVA_EN
        ITERA: begin
          if (mdv_done) begin
            resultado_r <= mdv_resultado;
            desvio_r    <= 1'b0;
            res_valid_r <= 1'b1;
            estado      <= RESPONDE;
          end
        end
`endif
        RESPONDE: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            estado      <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  // instr_ready also looks at reset so nothing is offered while reset is held low.
  assign bus.instr_ready = (estado == OCIOSO) && reset;
  assign bus.ocupado     = (estado != OCIOSO);
  assign bus.opcode_ula  = opcode_r;
  assign bus.funct_ula   = funct_r;
  assign bus.a_ula       = a_r;
  assign bus.b_ula       = b_r;
  assign bus.resultado   = resultado_r;
  assign bus.desvio      = desvio_r;
  assign bus.res_valid   = res_valid_r;

endmodule

// File: tb/tb_ula_sequenciador.sv
// tb_ula_sequenciador: self-checking bench for ula_sequenciador.
// Supplies a behavioural ULA on the bus, drives directed and random instructions,
// and compares operands, results, latency and handshake behaviour against a
// reference computed from the instruction rules. Works with or without ULA_ITERATIVA_EN.
`timescale 1ns/1ps
module tb_ula_sequenciador;
  import ula_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  ula_sequenciador_if bus ();

  ula_sequenciador dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural combinational ULA: returns {zero, resultado}.
  function automatic logic [32:0] ula_modelo(input logic [5:0] op, input logic [5:0] fn,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        z;
    r = '0;
    z = 1'b0;
    case (op)
      OP_ARIT: begin
        case (fn)
          6'd0:    r = a + b;
          6'd1:    r = a - b;
          FN_MULT: r = a * b;
          FN_DIV:  r = (b == 0) ? '0 : a / b;
          6'd4:    r = a & b;
          6'd5:    r = a | b;
          default: r = '0;
        endcase
        z = (r == 0);
      end
      OP_LOG:                             begin r = a ^ b; z = (r == 0); end
      OP_ADDI, OP_LOAD, OP_STORE, OP_IN:  begin r = a + b; z = (r == 0); end
      OP_PID:                             begin r = a + b; z = (r == 0); end
      OP_SUBI:                            begin r = a - b; z = (r == 0); end
      OP_BEQ:                             begin r = a - b; z = (a == b); end
      OP_BNE:                             begin r = a - b; z = (a != b); end
      default: ;
    endcase
    return {z, r};
  endfunction

  assign {bus.zero_ula, bus.resultado_ula} =
    ula_modelo(bus.opcode_ula, bus.funct_ula, bus.a_ula, bus.b_ula);

  // Second operand as the instruction rules define it.
  function automatic logic [31:0] operando_b(input logic [31:0] instr, input logic [31:0] d2);
    logic [5:0] op;
    op = instr[31:26];
    if (op inside {6'd2, 6'd6, 6'd7, 6'd8, 6'd20, 6'd28}) return 32'($signed(instr[15:0]));
    return d2;
  endfunction

  task automatic esperado(input logic [31:0] instr, input logic [31:0] d1, input logic [31:0] d2,
                          output logic [31:0] res, output logic z, output int lat);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] b;
    op = instr[31:26];
    fn = instr[5:0];
    b  = operando_b(instr, d2);
`ifdef ULA_ITERATIVA_EN
    if (op == 6'd0 && (fn == 6'd2 || fn == 6'd3)) begin
      res = (fn == 6'd2) ? d1 * b : ((b == 0) ? 32'hFFFF_FFFF : d1 / b);
      z   = 1'b0;
      lat = 33;
      return;
    end
`endif
    {z, res} = ula_modelo(op, fn, d1, b);
    lat = 2;
  endtask

  // Called #1 after the accept edge; waits for the result, holds it for 'espera' cycles, releases it.
  task automatic espera_resposta(input string tag, input int exp_lat, input logic [31:0] exp_res,
                                 input logic exp_z, input int espera);
    int n = 1;
    while (!bus.res_valid && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, " latencia"}, n, exp_lat);
    check({tag, " resultado"}, bus.resultado, exp_res);
    check({tag, " desvio"}, bus.desvio, exp_z);
    for (int i = 0; i < espera; i++) begin
      bus.instr_valid = 1'b1;
      bus.instrucao   = $urandom;
      bus.dados_1     = $urandom;
      @(posedge clock); #1;
      check({tag, " instr_ready retido"}, bus.instr_ready, 1'b0);
      check({tag, " res_valid retido"}, bus.res_valid, 1'b1);
      check({tag, " resultado retido"}, bus.resultado, exp_res);
      check({tag, " desvio retido"}, bus.desvio, exp_z);
    end
    bus.instr_valid = 1'b0;
    bus.res_ready   = 1'b1;
    @(posedge clock); #1;
    bus.res_ready   = 1'b0;
    check({tag, " res_valid liberado"}, bus.res_valid, 1'b0);
    check({tag, " ocupado liberado"}, bus.ocupado, 1'b0);
    check({tag, " instr_ready liberado"}, bus.instr_ready, 1'b1);
  endtask

  // Called #1 after an edge with the sequencer idle.
  task automatic transacao(input string tag, input logic [31:0] instr, input logic [31:0] d1,
                           input logic [31:0] d2, input int espera);
    logic [31:0] exp_res;
    logic        exp_z;
    int          exp_lat;
    esperado(instr, d1, d2, exp_res, exp_z, exp_lat);
    check({tag, " instr_ready inicial"}, bus.instr_ready, 1'b1);
    bus.instr_valid = 1'b1;
    bus.instrucao   = instr;
    bus.dados_1     = d1;
    bus.dados_2     = d2;
    @(posedge clock); #1;
    bus.instr_valid = 1'b0;
    bus.instrucao   = $urandom;
    bus.dados_1     = $urandom;
    bus.dados_2     = $urandom;
    check({tag, " ocupado"}, bus.ocupado, 1'b1);
    check({tag, " opcode_ula"}, bus.opcode_ula, instr[31:26]);
    check({tag, " funct_ula"}, bus.funct_ula, instr[5:0]);
    check({tag, " a_ula"}, bus.a_ula, d1);
    check({tag, " b_ula"}, bus.b_ula, operando_b(instr, d2));
    espera_resposta(tag, exp_lat, exp_res, exp_z, espera);
    check({tag, " a_ula mantido"}, bus.a_ula, d1);
  endtask

  function automatic logic [31:0] monta(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] instr_a, instr_b, d1, d2, exp_res;
    logic        exp_z;
    int          exp_lat;
    logic [5:0]  ops [12];
    logic [5:0]  op;

    ops = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd6, 6'd7, 6'd8, 6'd10, 6'd11, 6'd20, 6'd28};

    bus.instr_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.instrucao   = '0;
    bus.dados_1     = '0;
    bus.dados_2     = '0;

    // Power-on reset.
    repeat (3) @(posedge clock);
    #1;
    check("reset instr_ready", bus.instr_ready, 1'b0);
    check("reset res_valid", bus.res_valid, 1'b0);
    check("reset a_ula", bus.a_ula, 32'd0);
    check("reset resultado", bus.resultado, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("pos-reset instr_ready", bus.instr_ready, 1'b1);

    // Directed cases.
    transacao("ADD", monta(6'd0, 16'd0), 32'd7, 32'd5, 0);
    transacao("ADDI", monta(6'd2, 16'hFFFF), 32'd10, 32'd1234, 1);
    transacao("BEQ", monta(6'd10, 16'd0), 32'd3, 32'd3, 5);
    transacao("BNE", monta(6'd11, 16'd0), 32'd3, 32'd3, 0);
    transacao("DIV", monta(6'd0, 16'd3), 32'd100, 32'd7, 0);
    transacao("DIV0", monta(6'd0, 16'd3), 32'd100, 32'd0, 0);
    transacao("MULT", monta(6'd0, 16'd2), 32'h0001_0003, 32'h0002_0005, 0);
    transacao("DESCONHECIDO", monta(6'd45, 16'd0), 32'd9, 32'd9, 0);

    // Reset mid-operation: nothing survives, no late result.
    bus.instr_valid = 1'b1;
    bus.instrucao   = monta(6'd0, 16'd3);
    bus.dados_1     = 32'd1000;
    bus.dados_2     = 32'd3;
    @(posedge clock); #1;
    bus.instr_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("rst instr_ready", bus.instr_ready, 1'b0);
      check("rst ocupado", bus.ocupado, 1'b0);
      check("rst res_valid", bus.res_valid, 1'b0);
      check("rst resultado", bus.resultado, 32'd0);
      check("rst desvio", bus.desvio, 1'b0);
      check("rst opcode/funct", {bus.opcode_ula, bus.funct_ula}, 32'd0);
      check("rst a_ula", bus.a_ula, 32'd0);
      check("rst b_ula", bus.b_ula, 32'd0);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst liberado instr_ready", bus.instr_ready, 1'b1);
    repeat (40) @(posedge clock);
    #1;
    check("rst sem resultado tardio", bus.res_valid, 1'b0);
    transacao("DIV pos-reset", monta(6'd0, 16'd3), 32'd1000, 32'd3, 0);

    // Back-to-back: instr_valid held high across two instructions.
    instr_a = monta(6'd0, 16'd0);
    instr_b = monta(6'd0, 16'd1);
    bus.instr_valid = 1'b1;
    bus.instrucao   = instr_a;
    bus.dados_1     = 32'd1;
    bus.dados_2     = 32'd2;
    @(posedge clock); #1;
    bus.instrucao   = instr_b;
    bus.dados_1     = 32'd50;
    bus.dados_2     = 32'd8;
    check("hs A aceito", bus.a_ula, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("hs instr_ready ocupado", bus.instr_ready, 1'b0);
      check("hs B nao aceito", bus.a_ula, 32'd1);
    end
    check("hs A resultado", bus.resultado, 32'd3);
    bus.res_ready = 1'b1;
    @(posedge clock); #1;
    bus.res_ready = 1'b0;
    check("hs ocioso apos A", bus.instr_ready, 1'b1);
    check("hs B ainda nao aceito", bus.a_ula, 32'd1);
    @(posedge clock); #1;
    bus.instr_valid = 1'b0;
    check("hs B aceito ocupado", bus.ocupado, 1'b1);
    check("hs B a_ula", bus.a_ula, 32'd50);
    check("hs B funct", bus.funct_ula, 6'd1);
    esperado(instr_b, 32'd50, 32'd8, exp_res, exp_z, exp_lat);
    espera_resposta("hs B", exp_lat, exp_res, exp_z, 0);

    // Randomized instructions against the reference.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(29, 63));
      else                           op = ops[$urandom_range(0, 11)];
      instr_a        = $urandom;
      instr_a[31:26] = op;
      instr_a[5:0]   = 6'($urandom_range(0, 5));
      d1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
      d2 = ($urandom_range(0, 3) == 0) ? d1 : 32'($urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) d2 = $urandom;
      transacao("aleatorio", instr_a, d1, d2, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
